// File: rtl/divide_unit.sv
// divide_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Restoring radix-2 division, one quotient bit per clock, with early
// completion for divide-by-zero and signed overflow. Results are written
// back through a registered one-cycle strobe in the DONE state.
module divide_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  funct3,
  input  logic [4:0]  rd_in,
  input  logic [31:0] OP_1,
  input  logic [31:0] OP_2,
  output logic        busy,
  output logic [31:0] Result_to_Register,
  output logic [4:0]  Result_Addr,
  output logic        Reg_Write_En
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Latched request and iteration state
  logic        want_rem;
  logic [4:0]  rd_lat;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [5:0]  count;
  logic        neg_q;
  logic        neg_r;

  // Request decode (valid while IDLE with start)
  logic        is_signed;
  logic        div_zero;
  logic        overflow;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] special_result;

  // One restoring step on a 33-bit partial remainder
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic        last_iter;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
  logic [31:0] calc_result;

  assign is_signed = ~funct3[0];
  assign div_zero  = (OP_2 == 32'd0);
  assign overflow  = is_signed && (OP_1 == 32'h8000_0000) && (OP_2 == 32'hFFFF_FFFF);
  assign abs_a     = (is_signed && OP_1[31]) ? (~OP_1 + 32'd1) : OP_1;
  assign abs_b     = (is_signed && OP_2[31]) ? (~OP_2 + 32'd1) : OP_2;

  // Divide by zero: quotient all ones, remainder is the raw dividend.
  // Signed overflow: quotient is the most negative value, remainder zero.
  assign special_result = div_zero ? (funct3[1] ? OP_1 : 32'hFFFF_FFFF)
                                   : (funct3[1] ? 32'd0 : 32'h8000_0000);

  // A set bit 32 in the shifted remainder already guarantees it exceeds the divisor.
  assign shifted   = {rem, quo[31]};
  assign diff      = shifted - {1'b0, divisor};
  assign q_bit     = shifted[32] | ~diff[32];
  assign rem_step  = q_bit ? diff[31:0] : shifted[31:0];
  assign quo_step  = {quo[30:0], q_bit};
  assign last_iter = (count == 6'd31);

  // Quotient negated on differing signs; remainder follows the dividend sign.
  assign quo_final   = neg_q ? (~quo_step + 32'd1) : quo_step;
  assign rem_final   = neg_r ? (~rem_step + 32'd1) : rem_step;
  assign calc_result = want_rem ? rem_final : quo_final;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: special cases bypass CALC, start ignored while busy
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (div_zero || overflow) begin
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch request, iterate, and register the write-back outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy               <= 1'b0;
      Reg_Write_En       <= 1'b0;
      Result_to_Register <= 32'd0;
      Result_Addr        <= 5'd0;
      want_rem           <= 1'b0;
      rd_lat             <= 5'd0;
      divisor            <= 32'd0;
      quo                <= 32'd0;
      rem                <= 32'd0;
      count              <= 6'd0;
      neg_q              <= 1'b0;
      neg_r              <= 1'b0;
    end else begin
      busy         <= (state_next != IDLE);
      Reg_Write_En <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            want_rem <= funct3[1];
            rd_lat   <= rd_in;
            divisor  <= abs_b;
            quo      <= abs_a;
            rem      <= 32'd0;
            count    <= 6'd0;
            neg_q    <= is_signed && (OP_1[31] ^ OP_2[31]);
            neg_r    <= is_signed && OP_1[31];
            if (div_zero || overflow) begin
              Result_to_Register <= special_result;
              Result_Addr        <= rd_in;
              Reg_Write_En       <= (rd_in != 5'd0);
            end
          end
        end
        CALC: begin
          quo   <= quo_step;
          rem   <= rem_step;
          count <= count + 6'd1;
          if (last_iter) begin
            Result_to_Register <= calc_result;
            Result_Addr        <= rd_lat;
            Reg_Write_En       <= (rd_lat != 5'd0);
          end
        end
        DONE: begin
          Reg_Write_En <= 1'b0;
        end
        default: begin
          Reg_Write_En <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/divide_unit.md
DIVIDE_UNIT -- requirements
Module: divide_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  clock, all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 start  input  1  one-cycle request to begin a divide; sampled on rising clk.
REQ-004 funct3  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
REQ-005 rd_in  input  5  destination register address for the request.
REQ-006 OP_1  input  32  dividend, taken from the register file read port 1.
REQ-007 OP_2  input  32  divisor, taken from the register file read port 2.
REQ-008 busy  output  1  high while a request is in flight (CALC or DONE); the core stalls its PC while it is high.
REQ-009 Result_to_Register  output  32  result data to the register file write port.
REQ-010 Result_Addr  output  5  register file write address.
REQ-011 Reg_Write_En  output  1  register file write strobe; high for exactly one clk cycle per completed request.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 In IDLE with start=1 the block SHALL latch OP_1, OP_2, funct3 and rd_in on the rising edge.
- It then enters CALC, or enters DONE directly for the special cases in REQ-018 and REQ-019.
REQ-014 start SHALL be ignored in CALC and DONE; no queueing.
REQ-015 For signed operations (DIV, REM) the block SHALL divide the absolute values unsigned.
- The quotient is negated when the operand signs differ.
- The remainder takes the sign of the dividend.
REQ-016 CALC SHALL perform a restoring radix-2 division, one quotient bit per cycle.
- It uses a 6-bit iteration counter and runs exactly 32 cycles, then moves to DONE.
REQ-017 DONE SHALL last one cycle and return to IDLE.
- Result_to_Register carries the quotient for DIV/DIVU and the remainder for REM/REMU.
- Result_Addr = latched rd_in.
- Reg_Write_En = 1, unless latched rd_in = 0, in which case Reg_Write_En = 0.
REQ-018 Divide by zero (OP_2 = 0) SHALL skip CALC.
- Quotient = 0xFFFFFFFF; remainder = OP_1.
- Result appears in DONE on the cycle after start.
REQ-019 Signed overflow (DIV/REM with OP_1 = 0x80000000 and OP_2 = 0xFFFFFFFF) SHALL skip CALC.
- Quotient = 0x80000000; remainder = 0.
REQ-020 Latency: normal operations SHALL have Reg_Write_En high in the 33rd cycle after the start edge; special cases in the 1st.
REQ-021 Result_to_Register, Result_Addr and Reg_Write_En SHALL be registered and stable for the whole DONE cycle.
- The register file samples them on the falling clk edge inside that cycle.
REQ-022 Outside DONE, Reg_Write_En SHALL be 0; Result_to_Register and Result_Addr SHALL hold their last values.
REQ-023 busy SHALL rise on the edge that accepts start and fall on the edge that leaves DONE.
- A new start is therefore accepted on the cycle after DONE, at the earliest.
REQ-024 Internal arithmetic SHALL use a 33-bit partial remainder so that no intermediate subtraction overflows.

Reset
REQ-025 On reset assertion, regardless of clk, the block SHALL enter IDLE and clear all state.
- busy = 0, Reg_Write_En = 0, Result_to_Register = 0, Result_Addr = 0, iteration counter = 0.
REQ-026 Reset during CALC or DONE SHALL abort the operation with no write strobe issued.
REQ-027 After reset deasserts, the first start SHALL be accepted on the next rising clk edge.

Verification
REQ-028 DIVU, OP_1=100, OP_2=7, rd_in=5 -> busy for 33 cycles; in DONE: Result_to_Register=14, Result_Addr=5, Reg_Write_En=1 for one cycle.
REQ-029 REM, OP_1=0xFFFFFFF9 (-7), OP_2=2 -> Result_to_Register=0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-030 DIV, OP_2=0, OP_1=0x12345678 -> DONE on the next cycle with 0xFFFFFFFF; REMU with the same operands -> 0x12345678.
REQ-031 DIV, OP_1=0x80000000, OP_2=0xFFFFFFFF -> 0x80000000 after one cycle; REM with the same operands -> 0.
REQ-032 Start DIVU with rd_in=0, then pulse start again mid-CALC -> no Reg_Write_En at any point; the second start is ignored; busy falls after 33 cycles.
REQ-033 Assert reset in CALC cycle 10 -> busy=0 and outputs zero immediately (asynchronously), no write strobe; a new start of 9/3 then returns 3.
